// File: rtl/mem_copy64.sv
// mem_copy64: copies up to 64 words inside a 64-word single-port RAM.
// Each word takes a READ cycle (capture RAM data into a buffer) followed by a
// WRITE cycle (store the buffer at the destination). Addresses wrap modulo 64,
// and copying proceeds in ascending order, so overlapping forward copies
// replicate data. All outputs come straight from flops, and the async reset
// clears them at once, which also kills a write that is in flight.
module mem_copy64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  src,
  input  logic [5:0]  dst,
  input  logic [6:0]  len,
  output logic        busy,
  output logic        done,
  output logic [5:0]  mem_address,
  output logic [15:0] mem_in,
  output logic        mem_load,
  input  logic [15:0] mem_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  src_q, src_d;
  logic [5:0]  dst_q, dst_d;
  logic [6:0]  len_q, len_d;
  logic [6:0]  idx_q, idx_d;
  logic [15:0] buf_q, buf_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        load_q, load_d;
  logic [5:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [6:0]  len_sat_s;

  // Clamp the requested word count to the RAM size.
  always_comb begin
    len_sat_s = len;
    if (len > 7'd64) begin
      len_sat_s = 7'd64;
    end else begin
      len_sat_s = len;
    end
  end

  // Next-state logic: request capture, word sequencing and data buffering.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d = src;
          dst_d = dst;
          len_d = len_sat_s;
          idx_d = 7'd0;
          if (len_sat_s != 7'd0) begin
            state_d = ST_READ;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        buf_d   = mem_out;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        idx_d = idx_q + 7'd1;
        if ((idx_q + 7'd1) == len_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the outputs can be registered.
  always_comb begin
    busy_d  = 1'b0;
    done_d  = 1'b0;
    load_d  = 1'b0;
    addr_d  = 6'd0;
    wdata_d = 16'd0;
    case (state_d)
      ST_IDLE: begin
        busy_d = 1'b0;
      end
      ST_READ: begin
        busy_d = 1'b1;
        addr_d = src_d + idx_d[5:0];
      end
      ST_WRITE: begin
        busy_d  = 1'b1;
        load_d  = 1'b1;
        addr_d  = dst_d + idx_d[5:0];
        wdata_d = buf_d;
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      src_q   <= 6'd0;
      dst_q   <= 6'd0;
      len_q   <= 7'd0;
      idx_q   <= 7'd0;
      buf_q   <= 16'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      load_q  <= 1'b0;
      addr_q  <= 6'd0;
      wdata_q <= 16'd0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      load_q  <= load_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_load    = load_q;
  assign mem_address = addr_q;
  assign mem_in      = wdata_q;

endmodule
